// File: rtl/wavetable_pkg.sv
// Shared types and default sizing for the wavetable reader block.
package wavetable_pkg;

    localparam int WT_WIDTH_DEF       = 12;
    localparam int WT_DEPTH_DEF       = 512;
    localparam int WT_PHASE_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Two-entry sample buffer; head entry is presented from a register slot.
module sample_fifo #(
    parameter int dw_p = 13
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            push,
    input  logic [dw_p-1:0] push_data,
    input  logic            pop,
    output logic [dw_p-1:0] head_data,
    output logic [1:0]      count,
    output logic            full,
    output logic            empty
);

    logic [dw_p-1:0] mem_r [2];
    logic            wr_ptr_r;
    logic            rd_ptr_r;
    logic [1:0]      count_r;
    logic            pop_ok_s;
    logic            push_ok_s;

    // Qualify requests so a stray pop on empty or push on full cannot corrupt state.
    always_comb begin
        pop_ok_s  = pop & (count_r != 2'd0);
        push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_r[0] <= {dw_p{1'b0}};
            mem_r[1] <= {dw_p{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);

endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulator wavetable reader: issues table reads with one-cycle latency
// and buffers returned samples, tagging the first sample of each new period.
module wavetable_reader
    import wavetable_pkg::*;
#(
    parameter int width_p       = WT_WIDTH_DEF,
    parameter int depth_p       = WT_DEPTH_DEF,
    parameter int phase_width_p = WT_PHASE_WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       en_i,
    input  logic                       phase_clr_i,
    input  logic [phase_width_p-1:0]   tuning_i,
    output logic [$clog2(depth_p)-1:0] addr_o,
    input  logic [width_p-1:0]         table_data_i,
    input  logic                       table_valid_i,
    output logic [width_p-1:0]         sample_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       wrap_o,
    output logic                       err_o
);

    localparam int AW = $clog2(depth_p);

    state_e                   state_r;
    state_e                   state_nx_s;
    logic [phase_width_p-1:0] phase_r;
    logic [phase_width_p:0]   phase_sum_s;
    logic                     inflight_r;
    logic                     inflight_tag_r;
    logic                     wrap_pend_r;
    logic                     err_r;

    logic                     clr_s;
    logic                     issue_s;
    logic                     push_s;
    logic                     pop_s;
    logic [2:0]               occ_s;
    logic [width_p:0]         head_s;
    logic [1:0]               count_s;
    logic                     full_s;
    logic                     empty_s;

    // Next-state selection for the run/drain controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_i) state_nx_s = ST_RUN;
                else      state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!en_i) state_nx_s = ST_DRAIN;
                else       state_nx_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (en_i)                        state_nx_s = ST_RUN;
                else if (empty_s && !inflight_r) state_nx_s = ST_IDLE;
                else                             state_nx_s = ST_DRAIN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Issue decision: buffer slots plus the read in flight must leave room
    // after this cycle's pop. A clear in IDLE takes the cycle instead of a read.
    always_comb begin
        clr_s       = (state_r == ST_IDLE) && phase_clr_i;
        pop_s       = !empty_s && ready_i;
        push_s      = inflight_r && table_valid_i;
        occ_s       = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        phase_sum_s = {1'b0, phase_r} + {1'b0, tuning_i};
        issue_s     = ((state_r == ST_RUN) || en_i) && (occ_s < 3'd2)
                      && !(full_s && !pop_s) && !clr_s;
    end

    // Controller, phase accumulator, wrap tracking and sticky error.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r        <= ST_IDLE;
            phase_r        <= {phase_width_p{1'b0}};
            inflight_r     <= 1'b0;
            inflight_tag_r <= 1'b0;
            wrap_pend_r    <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            inflight_r <= issue_s;
            if (clr_s) begin
                phase_r     <= {phase_width_p{1'b0}};
                wrap_pend_r <= 1'b0;
            end else if (issue_s) begin
                phase_r        <= phase_sum_s[phase_width_p-1:0];
                inflight_tag_r <= wrap_pend_r;
                wrap_pend_r    <= phase_sum_s[phase_width_p];
            end
            // A missing return drops that sample; phase keeps advancing.
            if (inflight_r && !table_valid_i) begin
                err_r <= 1'b1;
            end
        end
    end

    sample_fifo #(
        .dw_p(width_p + 1)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (push_s),
        .push_data({inflight_tag_r, table_data_i}),
        .pop      (pop_s),
        .head_data(head_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign addr_o   = phase_r[phase_width_p-1 -: AW];
    assign sample_o = head_s[width_p-1:0];
    assign wrap_o   = head_s[width_p];
    assign valid_o  = !empty_s;
    assign err_o    = err_r;

endmodule

// File: doc/wavetable_reader.md
WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
REQ-001 SHALL have parameter width_p, default 12, table sample width in bits.
REQ-002 SHALL have parameter depth_p, default 512, table depth (power of two); aw = $clog2(depth_p).
REQ-003 SHALL have parameter phase_width_p, default 24, phase accumulator width (> aw).
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  1  run request; high permits issuing table reads.
REQ-007 phase_clr_i  input  1  clears phase accumulator; honoured only in IDLE.
REQ-008 tuning_i  input  phase_width_p  phase increment, sampled at each issue.
REQ-009 addr_o  output  aw  table address = phase[phase_width_p-1 -: aw].
REQ-010 table_data_i  input  width_p  table read data, valid one cycle after the address.
REQ-011 table_valid_i  input  1  table data qualifier for the return cycle.
REQ-012 sample_o  output  width_p  head-of-buffer sample.
REQ-013 valid_o  output  1  sample_o valid.
REQ-014 ready_i  input  1  downstream accepts; pop = valid_o & ready_i.
REQ-015 wrap_o  output  1  head sample is first of a new period; qualified by valid_o.
REQ-016 err_o  output  1  sticky: a return cycle saw table_valid_i low.

Function
REQ-017 SHALL keep states IDLE, RUN, DRAIN: IDLE->RUN on en_i; RUN->DRAIN on !en_i; DRAIN->RUN on en_i; DRAIN->IDLE when buffer empty and nothing in flight.
REQ-018 SHALL issue in RUN (or IDLE/DRAIN with en_i high, same cycle as transition) when count + inflight - pop < 2; issue: phase <= phase + tuning_i (mod 2^phase_width_p), inflight <= 1.
REQ-019 Table latency SHALL be exactly one cycle: data for addr_o at an issue cycle is captured from table_data_i on the next cycle if table_valid_i is high.
REQ-020 If inflight and table_valid_i low, the sample SHALL be dropped, err_o set to 1 until reset, phase not rewound.
REQ-021 SHALL hold captured samples in a 2-entry FIFO; push and pop in one cycle SHALL both occur, count unchanged; order preserved; no overflow possible by REQ-018.
REQ-022 Steady state with ready_i high SHALL sustain one sample per cycle; first valid_o two cycles after the issue-enabling edge of en_i.
REQ-023 A carry out of the phase addition SHALL set wrap_pending; the next issued sample carries tag 1 and clears wrap_pending; wrap_o = tag of head entry.
REQ-024 tuning_i = 0 SHALL repeat the same address every sample with wrap_o never set.
REQ-025 phase_clr_i outside IDLE SHALL be ignored; in IDLE it SHALL zero phase and wrap_pending.
REQ-026 ready_i low SHALL stall: no pop, issue stops once count + inflight = 2, phase frozen.

Reset
REQ-027 reset_ni low SHALL immediately force: state IDLE, phase 0, addr_o 0, inflight 0, FIFO empty, valid_o 0, sample_o 0, wrap_o 0, wrap_pending 0, err_o 0.
REQ-028 Reset mid-stream SHALL discard in-flight and buffered samples; after release no issue until en_i sampled high.

Structure
REQ-029 Package wavetable_pkg SHALL hold the state enum type and default parameter constants (width, depth, phase width).
REQ-030 The 2-entry buffer SHALL be sub-module sample_fifo (data width_p+1 including wrap tag, count/full/empty outputs).

Verification
REQ-031 Reset, en_i=1, tuning_i=0x008000, ready_i=1, ROM model -> addr_o 0,1,2,...; valid_o from cycle 2, one per cycle, sample_o = mem[0],mem[1],...
REQ-032 tuning_i=0x800000 -> addr_o 0,256,0,256; wrap_o=1 on each address-0 sample after the first, 0 on 256.
REQ-033 ready_i low 5 cycles mid-stream -> valid_o held, exactly 2 samples buffered, addr_o frozen; on release, no sample lost or duplicated.
REQ-034 table_valid_i low on one return cycle -> that sample missing, err_o=1 thereafter, stream continues with next address.
REQ-035 en_i low mid-stream -> DRAIN emits buffered samples then IDLE; phase_clr_i in IDLE -> addr_o 0; phase_clr_i in RUN -> no effect.
REQ-036 reset_ni low asynchronously mid-stream -> valid_o, sample_o, addr_o, err_o 0 before next clock edge.
